mac_sequencer: RTL
==================

// Module: mac_sequencer
// PURPOSE
//  Control FSM for the MAC datapath built from d_flip_flop register banks.
//  Accepts a job of LEN operand pairs via a valid/ready stream.
//  Drives load/clear/enable strobes to the operand, product and accumulator
//  registers, then holds the result valid until the consumer takes it.
//  Holds no datapath bits; it sequences only the register enables.
// PARAMETERS
//  CNT_W   4   width of the job length and remaining counter; max LEN = 2^CNT_W-1
// PORTS
//  clk        in   1      single clock; all state changes on rising edge
//  rst        in   1      asynchronous reset, active-high
//  start      in   1      job request; sampled only in IDLE
//  len        in   CNT_W  operand pairs in the job; sampled with start
//  in_valid   in   1      upstream operand pair present
//  in_ready   out  1      sequencer accepts an operand pair this cycle
//  op_load    out  1      operand registers capture this edge
//  acc_clr    out  1      accumulator clears this edge
//  acc_en     out  1      accumulator adds the product register this edge
//  out_valid  out  1      accumulator holds the final result
//  out_ready  in   1      consumer takes the result
//  busy       out  1      high in every state except IDLE
//  remaining  out  CNT_W  operand pairs still to accept
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, remaining=0, acc_en flop=0.
//   All outputs are 0 while rst is high. Reset mid-job abandons the job.
//  States: IDLE, CLEAR, RUN, DRAIN, DONE.
//   Outputs decode from state (Moore): acc_clr=CLEAR, in_ready=RUN,
//   out_valid=DONE, busy=!IDLE.
//  IDLE: start=1 -> CLEAR, remaining<=len. start=0 -> stay. len is ignored when start=0.
//  CLEAR: one cycle with acc_clr=1. Next state is RUN if remaining!=0, else DONE.
//   A zero-length job therefore returns result 0.
//  RUN: in_ready=1 and op_load = in_valid & in_ready (combinational).
//   On each handshake, remaining decrements.
//   If the handshake happens with remaining==1 -> DRAIN.
//   With no handshake, state holds indefinitely; there is no timeout.
//  acc_en: a flop that registers op_load, so acc_en is op_load delayed one cycle.
//   The one-cycle delay matches the product register stage.
//   acc_en never asserts in IDLE, CLEAR or DONE.
//  DRAIN: one cycle in which acc_en=1 for the last pair, then -> DONE.
//  DONE: out_valid=1 until out_ready=1.
//   On the edge with out_valid & out_ready -> IDLE.
//   out_ready=0 holds DONE indefinitely.
//  start asserted in any state other than IDLE is ignored; it is not queued.
//   On the DONE->IDLE edge start is not sampled; it must be held into IDLE.
//  Latency: start edge -> CLEAR -> first in_ready on the next cycle.
//   Last handshake -> out_valid 2 cycles later (DRAIN, then DONE).
//  Counter: remaining never underflows. It is 0 in IDLE after a completed job.
//  The unused state encodings recover to IDLE on the next edge.
// TESTING
//  1. rst pulse mid-RUN with remaining=3 -> same cycle: busy=0, in_ready=0, acc_en=0; then IDLE.
//  2. start, len=3, in_valid held 1 -> acc_clr at cycle 1, op_load cycles 2-4,
//     acc_en cycles 3-5, out_valid from cycle 6.
//  3. len=4, in_valid toggled 1,0,1,0,... -> exactly 4 op_load and 4 acc_en pulses;
//     remaining steps 4,3,2,1,0.
//  4. len=0 -> CLEAR then DONE; zero op_load and zero acc_en pulses; out_valid=1.
//  5. DONE with out_ready=0 for 5 cycles, then 1 -> out_valid held 5 cycles, IDLE after the handshake.
//  6. start pulsed during RUN and DONE -> ignored; a new job starts only from IDLE.

Source files
------------

// File: rtl/mac_seq_if.sv
// rtl/mac_seq_if.sv - handshake and strobe bundle between the MAC job source/consumer and the sequencer
interface mac_seq_if #(
    parameter int CNT_W = 4
) ();
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic             op_load;
    logic             acc_clr;
    logic             acc_en;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, len, in_valid, out_ready,
        input  in_ready, op_load, acc_clr, acc_en, out_valid, busy, remaining
    );

    modport slave (
        input  start, len, in_valid, out_ready,
        output in_ready, op_load, acc_clr, acc_en, out_valid, busy, remaining
    );
endinterface

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - job FSM driving operand/product/accumulator register enables for the MAC datapath
module mac_sequencer #(
    parameter int CNT_W = 4
) (
    input logic       clk,
    input logic       rst,
    mac_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             acc_en_q, acc_en_d;
    logic             op_load;

    always_comb begin
        op_load     = bus.in_valid & (state_q == S_RUN);
        state_d     = state_q;
        remaining_d = remaining_q;
        // Product register adds one stage, so the accumulator enable trails the operand load.
        acc_en_d    = op_load;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_CLEAR;
                    remaining_d = bus.len;
                end
            end
            S_CLEAR: begin
                state_d = (remaining_q != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                if (op_load && remaining_q != '0) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                remaining_d = '0;
                acc_en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            acc_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_en_q    <= acc_en_d;
        end
    end

    assign bus.in_ready  = (state_q == S_RUN);
    assign bus.op_load   = op_load;
    assign bus.acc_clr   = (state_q == S_CLEAR);
    assign bus.acc_en    = acc_en_q;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.remaining = remaining_q;
endmodule
